// File: rtl/decode_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_if
//  Description : Bundle of the decode stage's fetch-side handshake, execute-
//                side handshake, flush, register-file write-back port and all
//                decoded, registered outputs.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Modports
//    slave  : the decode stage (drives o_*, samples i_*)
//    master : the surrounding pipeline / bench (drives i_*, samples o_*)
//  Signals
//    i_IF_VALID/o_IF_READY    fetch handshake
//    i_PC, i_INSTR            fetched PC / instruction word
//    i_EX_READY/o_EX_VALID    execute handshake
//    i_FLUSH                  discard held instruction
//    i_WB_WE/PTR/DATA         register-file write port
//    o_PC ... o_ILLEGAL       registered operands, fields and strobes
// ============================================================================
interface decode_if;
    logic        i_IF_VALID;
    logic        o_IF_READY;
    logic [31:0] i_PC;
    logic [31:0] i_INSTR;
    logic        i_EX_READY;
    logic        o_EX_VALID;
    logic        i_FLUSH;
    logic        i_WB_WE;
    logic [4:0]  i_WB_PTR;
    logic [31:0] i_WB_DATA;
    logic [31:0] o_PC;
    logic [31:0] o_INSTRUCTION;
    logic [31:0] o_RS1;
    logic [31:0] o_RS2;
    logic [31:0] o_IMM_VAL;
    logic [2:0]  o_FUNCT3;
    logic [6:0]  o_FUNCT7;
    logic [4:0]  o_RD_PTR;
    logic [1:0]  o_ALU_OP;
    logic        o_REG_WE;
    logic        o_MEM_WE;
    logic        o_MEM_RE;
    logic        o_ECALL;
    logic        o_IMM;
    logic        o_JAL;
    logic        o_LUI;
    logic        o_AUIPC;
    logic        o_ILLEGAL;

    modport slave (
        input  i_IF_VALID, i_PC, i_INSTR, i_EX_READY, i_FLUSH,
               i_WB_WE, i_WB_PTR, i_WB_DATA,
        output o_IF_READY, o_EX_VALID, o_PC, o_INSTRUCTION, o_RS1, o_RS2,
               o_IMM_VAL, o_FUNCT3, o_FUNCT7, o_RD_PTR, o_ALU_OP,
               o_REG_WE, o_MEM_WE, o_MEM_RE, o_ECALL, o_IMM, o_JAL,
               o_LUI, o_AUIPC, o_ILLEGAL
    );

    modport master (
        output i_IF_VALID, i_PC, i_INSTR, i_EX_READY, i_FLUSH,
               i_WB_WE, i_WB_PTR, i_WB_DATA,
        input  o_IF_READY, o_EX_VALID, o_PC, o_INSTRUCTION, o_RS1, o_RS2,
               o_IMM_VAL, o_FUNCT3, o_FUNCT7, o_RD_PTR, o_ALU_OP,
               o_REG_WE, o_MEM_WE, o_MEM_RE, o_ECALL, o_IMM, o_JAL,
               o_LUI, o_AUIPC, o_ILLEGAL
    );
endinterface
`default_nettype wire

// File: rtl/decode.sv
`default_nettype none
// ============================================================================
//  Module      : decode
//  Description : RV32I decode stage. Holds a 32x32 register file, decodes the
//                fetched instruction and registers operands, immediate,
//                fields and control strobes behind a valid/ready handshake.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    HART_ID  hart identifier, carried for the hierarchy only
//  Ports
//    i_CLK    clock, rising edge
//    i_RSTn   asynchronous active-low reset
//    bus      decode_if.slave (handshakes, write-back port, decoded outputs)
//  Build options
//    DECODE_WB_BYPASS_EN  when defined, a same-cycle write-back to rs1/rs2 is
//                         forwarded into the captured operand
// ============================================================================
module decode #(
    parameter logic [31:0] HART_ID = 32'h0000_0000
) (
    input  wire logic  i_CLK,
    input  wire logic  i_RSTn,
    decode_if.slave    bus
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic reg_we;
        logic mem_we;
        logic mem_re;
        logic ecall;
        logic imm;
        logic jal;
        logic lui;
        logic auipc;
        logic illegal;
    } ctrl_t;

    logic unused_hart_id;
    assign unused_hart_id = ^HART_ID;

    // ------------------------------------------------------------------
    // Register file (x0 never written, reads of x0 forced to zero)
    // ------------------------------------------------------------------
    logic [31:0] regs_q [32];
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_rf;
    logic [31:0] rs2_rf;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    assign rs1_idx = bus.i_INSTR[19:15];
    assign rs2_idx = bus.i_INSTR[24:20];
    assign rs1_rf  = (rs1_idx == 5'd0) ? 32'h0 : regs_q[rs1_idx];
    assign rs2_rf  = (rs2_idx == 5'd0) ? 32'h0 : regs_q[rs2_idx];

    always_ff @(posedge i_CLK) begin
        if (bus.i_WB_WE && (bus.i_WB_PTR != 5'd0)) begin
            regs_q[bus.i_WB_PTR] <= bus.i_WB_DATA;
        end
    end

`ifdef DECODE_WB_BYPASS_EN
    logic wb_live;
    assign wb_live = bus.i_WB_WE && (bus.i_WB_PTR != 5'd0);
    assign rs1_val = (wb_live && (bus.i_WB_PTR == rs1_idx)) ? bus.i_WB_DATA : rs1_rf;
    assign rs2_val = (wb_live && (bus.i_WB_PTR == rs2_idx)) ? bus.i_WB_DATA : rs2_rf;
`else
    // The write lands at the same edge as the capture, so the captured
    // operand is the pre-write value.
    assign rs1_val = rs1_rf;
    assign rs2_val = rs2_rf;
`endif

    // ------------------------------------------------------------------
    // Combinational instruction decode
    // ------------------------------------------------------------------
    logic [31:0] ins;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    ctrl_t       dec_ctrl;
    logic [1:0]  dec_alu_op;
    logic [31:0] dec_imm;

    assign ins   = bus.i_INSTR;
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'h000};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    always_comb begin
        dec_ctrl   = '0;
        dec_alu_op = 2'b00;
        dec_imm    = 32'h0;
        // The opcode compare covers instr[1:0], so a non-32-bit encoding
        // always falls through to the illegal default.
        case (ins[6:0])
            OPC_OP: begin
                dec_alu_op      = 2'b01;
                dec_ctrl.reg_we = 1'b1;
            end
            OPC_OP_IMM: begin
                dec_alu_op      = 2'b01;
                dec_ctrl.imm    = 1'b1;
                dec_ctrl.reg_we = 1'b1;
                dec_imm         = imm_i;
            end
            OPC_LOAD: begin
                dec_ctrl.imm    = 1'b1;
                dec_ctrl.mem_re = 1'b1;
                dec_ctrl.reg_we = 1'b1;
                dec_imm         = imm_i;
            end
            OPC_STORE: begin
                dec_ctrl.imm    = 1'b1;
                dec_ctrl.mem_we = 1'b1;
                dec_imm         = imm_s;
            end
            OPC_LUI: begin
                dec_ctrl.lui    = 1'b1;
                dec_ctrl.imm    = 1'b1;
                dec_ctrl.reg_we = 1'b1;
                dec_imm         = imm_u;
            end
            OPC_AUIPC: begin
                dec_ctrl.auipc  = 1'b1;
                dec_ctrl.imm    = 1'b1;
                dec_ctrl.reg_we = 1'b1;
                dec_imm         = imm_u;
            end
            OPC_JAL: begin
                dec_ctrl.jal    = 1'b1;
                dec_ctrl.imm    = 1'b1;
                dec_ctrl.reg_we = 1'b1;
                dec_imm         = imm_j;
            end
            OPC_JALR: begin
                dec_ctrl.imm    = 1'b1;
                dec_ctrl.reg_we = 1'b1;
                dec_imm         = imm_i;
            end
            OPC_BRANCH: begin
                dec_alu_op = 2'b10;
                dec_imm    = imm_b;
            end
            OPC_SYSTEM: begin
                // ECALL/EBREAK have funct3==0; CSR ops write rd.
                dec_ctrl.ecall  = 1'b1;
                dec_ctrl.reg_we = (ins[14:12] != 3'b000);
                dec_imm         = imm_i;
            end
            default: begin
                dec_ctrl.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and pipeline register
    // ------------------------------------------------------------------
    logic        ex_valid_q, ex_valid_d;
    ctrl_t       ctrl_q,     ctrl_d;
    logic [1:0]  alu_op_q,   alu_op_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] rs1_q,      rs1_d;
    logic [31:0] rs2_q,      rs2_d;
    logic [31:0] imm_val_q,  imm_val_d;
    logic        if_ready;
    logic        capture;

    assign if_ready = ~ex_valid_q | bus.i_EX_READY;
    assign capture  = bus.i_IF_VALID & if_ready & ~bus.i_FLUSH;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ctrl_d     = ctrl_q;
        alu_op_d   = alu_op_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        imm_val_d  = imm_val_q;
        if (bus.i_FLUSH) begin
            ex_valid_d = 1'b0;
            ctrl_d     = '0;
        end else if (capture) begin
            ex_valid_d = 1'b1;
            ctrl_d     = dec_ctrl;
            alu_op_d   = dec_alu_op;
            pc_d       = bus.i_PC;
            instr_d    = bus.i_INSTR;
            rs1_d      = rs1_val;
            rs2_d      = rs2_val;
            imm_val_d  = dec_imm;
        end else if (bus.i_EX_READY) begin
            // Consumed with nothing behind it: strobes drop with valid so
            // downstream never sees a side-effect strobe without valid.
            ex_valid_d = 1'b0;
            ctrl_d     = '0;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= '0;
            alu_op_q   <= 2'b00;
            pc_q       <= 32'h0;
            instr_q    <= 32'h0;
            rs1_q      <= 32'h0;
            rs2_q      <= 32'h0;
            imm_val_q  <= 32'h0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ctrl_q     <= ctrl_d;
            alu_op_q   <= alu_op_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_val_q  <= imm_val_d;
        end
    end

    // Fields are slices of the registered instruction word.
    assign bus.o_IF_READY    = if_ready;
    assign bus.o_EX_VALID    = ex_valid_q;
    assign bus.o_PC          = pc_q;
    assign bus.o_INSTRUCTION = instr_q;
    assign bus.o_RS1         = rs1_q;
    assign bus.o_RS2         = rs2_q;
    assign bus.o_IMM_VAL     = imm_val_q;
    assign bus.o_FUNCT3      = instr_q[14:12];
    assign bus.o_FUNCT7      = instr_q[31:25];
    assign bus.o_RD_PTR      = instr_q[11:7];
    assign bus.o_ALU_OP      = alu_op_q;
    assign bus.o_REG_WE      = ctrl_q.reg_we;
    assign bus.o_MEM_WE      = ctrl_q.mem_we;
    assign bus.o_MEM_RE      = ctrl_q.mem_re;
    assign bus.o_ECALL       = ctrl_q.ecall;
    assign bus.o_IMM         = ctrl_q.imm;
    assign bus.o_JAL         = ctrl_q.jal;
    assign bus.o_LUI         = ctrl_q.lui;
    assign bus.o_AUIPC       = ctrl_q.auipc;
    assign bus.o_ILLEGAL     = ctrl_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode
//  Description : Directed self-checking bench for the decode stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    decode_if bus ();

    decode #(.HART_ID(32'h0000_0000)) u_dut (
        .i_CLK  (clk),
        .i_RSTn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] ptr, input logic [31:0] data);
        bus.i_WB_WE   = 1'b1;
        bus.i_WB_PTR  = ptr;
        bus.i_WB_DATA = data;
        tick();
        bus.i_WB_WE   = 1'b0;
    endtask

    // Present one instruction for one cycle with EX ready.
    task automatic issue(input logic [31:0] pc, input logic [31:0] instr);
        bus.i_IF_VALID = 1'b1;
        bus.i_PC       = pc;
        bus.i_INSTR    = instr;
        bus.i_EX_READY = 1'b1;
        tick();
        bus.i_IF_VALID = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n          = 1'b0;
        bus.i_IF_VALID = 1'b0;
        bus.i_PC       = 32'h0;
        bus.i_INSTR    = 32'h0;
        bus.i_EX_READY = 1'b1;
        bus.i_FLUSH    = 1'b0;
        bus.i_WB_WE    = 1'b0;
        bus.i_WB_PTR   = 5'd0;
        bus.i_WB_DATA  = 32'h0;
        repeat (3) tick();

        check_eq("rst_ex_valid", bus.o_EX_VALID, 32'h0);
        check_eq("rst_reg_we",   bus.o_REG_WE,   32'h0);
        check_eq("rst_imm_val",  bus.o_IMM_VAL,  32'h0);
        check_eq("rst_pc",       bus.o_PC,       32'h0);
        check_eq("rst_if_ready", bus.o_IF_READY, 32'h1);
        rst_n = 1'b1;
        tick();

        wb_write(5'd1, 32'h1111_1111);
        wb_write(5'd2, 32'h2222_2222);
        wb_write(5'd3, 32'h3333_3333);

        // addi x1,x0,5
        issue(32'h0000_0100, 32'h0050_0093);
        check_eq("addi_valid",  bus.o_EX_VALID, 32'h1);
        check_eq("addi_imm",    bus.o_IMM,      32'h1);
        check_eq("addi_aluop",  bus.o_ALU_OP,   32'h1);
        check_eq("addi_immval", bus.o_IMM_VAL,  32'h5);
        check_eq("addi_rd",     bus.o_RD_PTR,   32'h1);
        check_eq("addi_rs1",    bus.o_RS1,      32'h0);
        check_eq("addi_regwe",  bus.o_REG_WE,   32'h1);
        check_eq("addi_pc",     bus.o_PC,       32'h0000_0100);

        // sw x1,-4(x2)
        issue(32'h0000_0104, 32'hFE11_2E23);
        check_eq("sw_memwe",  bus.o_MEM_WE,  32'h1);
        check_eq("sw_regwe",  bus.o_REG_WE,  32'h0);
        check_eq("sw_immval", bus.o_IMM_VAL, 32'hFFFF_FFFC);
        check_eq("sw_rs1",    bus.o_RS1,     32'h2222_2222);
        check_eq("sw_rs2",    bus.o_RS2,     32'h1111_1111);
        check_eq("sw_funct3", bus.o_FUNCT3,  32'h2);

        // Stall 3 cycles with lui x5,0x12345 waiting at fetch
        bus.i_EX_READY = 1'b0;
        bus.i_IF_VALID = 1'b1;
        bus.i_PC       = 32'h0000_0108;
        bus.i_INSTR    = 32'h1234_52B7;
        #1;
        check_eq("stall_if_ready", bus.o_IF_READY, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_valid",  bus.o_EX_VALID, 32'h1);
            check_eq("stall_immval", bus.o_IMM_VAL,  32'hFFFF_FFFC);
            check_eq("stall_memwe",  bus.o_MEM_WE,   32'h1);
            check_eq("stall_pc",     bus.o_PC,       32'h0000_0104);
        end
        bus.i_EX_READY = 1'b1;
        #1;
        check_eq("unstall_if_ready", bus.o_IF_READY, 32'h1);
        tick();
        bus.i_IF_VALID = 1'b0;
        check_eq("lui_lui",    bus.o_LUI,     32'h1);
        check_eq("lui_immval", bus.o_IMM_VAL, 32'h1234_5000);
        check_eq("lui_rd",     bus.o_RD_PTR,  32'h5);
        check_eq("lui_memwe",  bus.o_MEM_WE,  32'h0);

        // Flush beats a same-cycle fetch
        bus.i_FLUSH = 1'b1;
        issue(32'h0000_010C, 32'h0050_0093);
        bus.i_FLUSH = 1'b0;
        check_eq("flush_valid", bus.o_EX_VALID, 32'h0);
        check_eq("flush_regwe", bus.o_REG_WE,   32'h0);

        // jal x1,8, then drain
        issue(32'h0000_0200, 32'h0080_00EF);
        check_eq("jal_jal",    bus.o_JAL,     32'h1);
        check_eq("jal_immval", bus.o_IMM_VAL, 32'h8);
        check_eq("jal_regwe",  bus.o_REG_WE,  32'h1);
        tick();
        check_eq("drain_valid", bus.o_EX_VALID, 32'h0);
        check_eq("drain_regwe", bus.o_REG_WE,   32'h0);

        // Illegal all-ones word
        issue(32'h0000_0204, 32'hFFFF_FFFF);
        check_eq("ill_valid",   bus.o_EX_VALID, 32'h1);
        check_eq("ill_illegal", bus.o_ILLEGAL,  32'h1);
        check_eq("ill_strobes", {23'h0, bus.o_REG_WE, bus.o_MEM_WE, bus.o_MEM_RE,
                                 bus.o_ECALL, bus.o_IMM, bus.o_JAL, bus.o_LUI,
                                 bus.o_AUIPC, bus.o_ALU_OP[1]}, 32'h0);
        check_eq("ill_aluop",   bus.o_ALU_OP,   32'h0);

        // addi with instr[1:0]=00 is illegal too
        issue(32'h0000_0208, 32'h0050_0090);
        check_eq("ill16_illegal", bus.o_ILLEGAL, 32'h1);
        check_eq("ill16_imm",     bus.o_IMM,     32'h0);

        // beq x1,x2,-8
        issue(32'h0000_020C, 32'hFE20_8CE3);
        check_eq("beq_immval", bus.o_IMM_VAL, 32'hFFFF_FFF8);
        check_eq("beq_aluop",  bus.o_ALU_OP,  32'h2);
        check_eq("beq_regwe",  bus.o_REG_WE,  32'h0);
        check_eq("beq_illegal", bus.o_ILLEGAL, 32'h0);

        // ecall, then csrrs x5,0x300,x0
        issue(32'h0000_0210, 32'h0000_0073);
        check_eq("ecall_ecall", bus.o_ECALL,  32'h1);
        check_eq("ecall_regwe", bus.o_REG_WE, 32'h0);
        issue(32'h0000_0214, 32'h3000_22F3);
        check_eq("csr_regwe",  bus.o_REG_WE,  32'h1);
        check_eq("csr_immval", bus.o_IMM_VAL, 32'h0000_0300);
        check_eq("csr_funct3", bus.o_FUNCT3,  32'h2);

        // lw x6,16(x1)
        issue(32'h0000_0218, 32'h0100_A303);
        check_eq("lw_memre",  bus.o_MEM_RE,  32'h1);
        check_eq("lw_regwe",  bus.o_REG_WE,  32'h1);
        check_eq("lw_immval", bus.o_IMM_VAL, 32'h10);
        check_eq("lw_rs1",    bus.o_RS1,     32'h1111_1111);

        // auipc x10,1
        issue(32'h0000_021C, 32'h0000_1517);
        check_eq("auipc_auipc",  bus.o_AUIPC,   32'h1);
        check_eq("auipc_immval", bus.o_IMM_VAL, 32'h0000_1000);

        // add x4,x3,x0 with same-cycle write x3
        bus.i_WB_WE   = 1'b1;
        bus.i_WB_PTR  = 5'd3;
        bus.i_WB_DATA = 32'hDEAD_BEEF;
        issue(32'h0000_0220, 32'h0001_8233);
        bus.i_WB_WE   = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
        check_eq("wb_same_rs1", bus.o_RS1, 32'hDEAD_BEEF);
`else
        check_eq("wb_same_rs1", bus.o_RS1, 32'h3333_3333);
`endif
        check_eq("add_aluop", bus.o_ALU_OP, 32'h1);
        issue(32'h0000_0224, 32'h0001_8233);
        check_eq("wb_next_rs1", bus.o_RS1, 32'hDEAD_BEEF);

        // write to x0 never visible
        bus.i_WB_WE   = 1'b1;
        bus.i_WB_PTR  = 5'd0;
        bus.i_WB_DATA = 32'h1234_5678;
        issue(32'h0000_0228, 32'h0000_0233);
        bus.i_WB_WE   = 1'b0;
        check_eq("x0_same_rs1", bus.o_RS1, 32'h0);
        issue(32'h0000_022C, 32'h0000_0233);
        check_eq("x0_next_rs1", bus.o_RS1, 32'h0);

        // Asynchronous reset in the middle of a stall
        bus.i_EX_READY = 1'b0;
        issue(32'h0000_0230, 32'h0050_0093);
        check_eq("prerst_valid", bus.o_EX_VALID, 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid",  bus.o_EX_VALID, 32'h0);
        check_eq("arst_regwe",  bus.o_REG_WE,   32'h0);
        check_eq("arst_immval", bus.o_IMM_VAL,  32'h0);
        check_eq("arst_rd",     bus.o_RD_PTR,   32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("postrst_valid", bus.o_EX_VALID, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
